// File: rtl/quadrature_pkg.sv
// Shared encoder-front-end constants: default filter depth, error counter width
// and the helper that sizes the per-channel stability counters.
package quadrature_pkg;

  localparam int unsigned FILTER_LEN_DEF = 8;
  localparam int unsigned ERR_W_DEF      = 16;

  // ceil(log2(len+1)): bits needed to hold the values 0..len
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// One encoder channel: 2-flop synchronizer, then a stability counter that only
// lets the filtered level follow after FILTER_LEN consecutive differing cycles.
module glitch_filter
  import quadrature_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk_12MHz,
  input  logic reset,
  input  logic raw,
  output logic filt,
  output logic toggle
);

  localparam int unsigned     CW   = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]   LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // High on the cycle whose edge flips filt; the top uses it to see
  // simultaneous A/B changes without an extra register stage.
  assign toggle = (sync[1] != filt) && (cnt == LAST);

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if ((sync[1] == filt) || toggle) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
      if (toggle) filt <= ~filt;
    end
  end

endmodule

// File: rtl/quadrature_input_filter.sv
// Quadrature encoder input conditioning: three glitch filters plus illegal
// A/B transition counting, index pulse generation and a post-reset mask.
module quadrature_input_filter
  import quadrature_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter int unsigned ERR_W      = ERR_W_DEF
) (
  input  logic             clk_12MHz,
  input  logic             reset,
  input  logic             A_raw,
  input  logic             B_raw,
  input  logic             I_raw,
  output logic             A,
  output logic             B,
  output logic             I,
  output logic             index_pulse,
  output logic [ERR_W-1:0] error_count,
  output logic             error_flag,
  input  logic             error_clear
);

  localparam int unsigned   MW        = cnt_width(FILTER_LEN + 2);
  localparam logic [MW-1:0] MASK_LOAD = MW'(FILTER_LEN + 2);

  logic          tog_a, tog_b, tog_i;
  logic [MW-1:0] mask_cnt;
  logic          masked;
  logic          illegal;
  logic          i_rise_q;

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk_12MHz (clk_12MHz), .reset (reset), .raw (A_raw), .filt (A), .toggle (tog_a)
  );
  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk_12MHz (clk_12MHz), .reset (reset), .raw (B_raw), .filt (B), .toggle (tog_b)
  );
  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clk_12MHz (clk_12MHz), .reset (reset), .raw (I_raw), .filt (I), .toggle (tog_i)
  );

  assign masked  = (mask_cnt != '0);
  assign illegal = tog_a && tog_b && !masked;

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) mask_cnt <= MASK_LOAD;
    else if (masked) mask_cnt <= mask_cnt - 1'b1;
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      error_count <= '0;
      error_flag  <= 1'b0;
    end else if (error_clear) begin
      error_count <= '0;
      error_flag  <= 1'b0;
    end else if (illegal) begin
      error_flag <= 1'b1;
      if (error_count != '1) error_count <= error_count + 1'b1;
    end
  end

  // Rise is captured on the edge that sets I, so the pulse lands one cycle after I goes high.
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      i_rise_q    <= 1'b0;
      index_pulse <= 1'b0;
    end else begin
      i_rise_q    <= tog_i && !I && !masked;
      index_pulse <= i_rise_q;
    end
  end

endmodule

// File: tb/tb_quadrature_input_filter.sv
// Self-checking bench for quadrature_input_filter: directed table, corner
// sequences and randomized raw inputs against a window-based reference model.
module tb_quadrature_input_filter;
  import quadrature_pkg::*;

  localparam int unsigned FL = 8;

  logic        clk_12MHz = 1'b0;
  logic        reset, A_raw, B_raw, I_raw, error_clear;
  logic        A, B, I, index_pulse, error_flag;
  logic [15:0] error_count;
  logic        A_s, B_s, I_s, index_pulse_s, error_flag_s;
  logic [1:0]  error_count_s;

  always #5 clk_12MHz = ~clk_12MHz;

  quadrature_input_filter #(.FILTER_LEN(FL), .ERR_W(16)) dut (
    .clk_12MHz (clk_12MHz), .reset (reset),
    .A_raw (A_raw), .B_raw (B_raw), .I_raw (I_raw),
    .A (A), .B (B), .I (I), .index_pulse (index_pulse),
    .error_count (error_count), .error_flag (error_flag), .error_clear (error_clear)
  );

  // Narrow counter instance so saturation is reachable in a few transitions.
  quadrature_input_filter #(.FILTER_LEN(FL), .ERR_W(2)) dut_s (
    .clk_12MHz (clk_12MHz), .reset (reset),
    .A_raw (A_raw), .B_raw (B_raw), .I_raw (I_raw),
    .A (A_s), .B (B_s), .I (I_s), .index_pulse (index_pulse_s),
    .error_count (error_count_s), .error_flag (error_flag_s), .error_clear (error_clear)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the last FL synchronized samples all differ.
  bit          ms1[3], ms2[3], mf[3];
  bit          mh[3][FL];
  int unsigned since;
  logic [15:0] mcnt;
  logic [1:0]  mcnt_s;
  bit          mflag, mpend, mpulse;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      ms1[c] = 0; ms2[c] = 0; mf[c] = 0;
      for (int k = 0; k < int'(FL); k++) mh[c][k] = 0;
    end
    since = 0; mcnt = '0; mcnt_s = '0; mflag = 0; mpend = 0; mpulse = 0;
  endtask

  task automatic model_step();
    bit masked;
    bit tg[3];
    bit rw[3];
    masked = (since < FL + 2);
    if (since < 1000) since++;
    rw[0] = A_raw; rw[1] = B_raw; rw[2] = I_raw;
    mpulse = mpend;
    mpend  = 0;
    for (int c = 0; c < 3; c++) begin
      bit all;
      for (int k = int'(FL) - 1; k > 0; k--) mh[c][k] = mh[c][k-1];
      mh[c][0] = ms2[c];
      all = 1;
      for (int k = 0; k < int'(FL); k++) if (mh[c][k] == mf[c]) all = 0;
      tg[c] = all;
      if (all) mf[c] = ~mf[c];
    end
    if (error_clear) begin
      mcnt = '0; mcnt_s = '0; mflag = 0;
    end else if (tg[0] && tg[1] && !masked) begin
      mflag = 1;
      if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      if (mcnt_s != 2'b11) mcnt_s = mcnt_s + 2'd1;
    end
    if (tg[2] && mf[2] && !masked) mpend = 1;
    for (int c = 0; c < 3; c++) begin
      ms2[c] = ms1[c];
      ms1[c] = rw[c];
    end
  endtask

  task automatic tick();
    @(posedge clk_12MHz);
    model_step();
    @(negedge clk_12MHz);
  endtask

  task automatic cmp_model(input int unsigned cyc);
    chk($sformatf("rnd%0d_A", cyc), {31'b0, A}, {31'b0, mf[0]});
    chk($sformatf("rnd%0d_B", cyc), {31'b0, B}, {31'b0, mf[1]});
    chk($sformatf("rnd%0d_I", cyc), {31'b0, I}, {31'b0, mf[2]});
    chk($sformatf("rnd%0d_idx", cyc), {31'b0, index_pulse}, {31'b0, mpulse});
    chk($sformatf("rnd%0d_cnt", cyc), {16'b0, error_count}, {16'b0, mcnt});
    chk($sformatf("rnd%0d_flag", cyc), {31'b0, error_flag}, {31'b0, mflag});
    chk($sformatf("rnd%0d_cnt_s", cyc), {30'b0, error_count_s}, {30'b0, mcnt_s});
  endtask

  typedef struct {
    logic [3:0]  in;   // {A_raw, B_raw, I_raw, error_clear}
    int unsigned n;    // rising edges to apply
    logic [3:0]  exp;  // {A, B, I, error_flag}
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] in, input int unsigned n,
                              input logic [3:0] exp, input logic [15:0] cnt);
    vec_t v;
    v.in = in; v.n = n; v.exp = exp; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(4'b1000,  9, 4'b0000, 16'd0);  // A not yet
    tbl[1]  = mk(4'b1000,  1, 4'b1000, 16'd0);  // A rises on 10th edge
    tbl[2]  = mk(4'b1100,  7, 4'b1000, 16'd0);  // 7-cycle B pulse
    tbl[3]  = mk(4'b1000, 12, 4'b1000, 16'd0);  // rejected
    tbl[4]  = mk(4'b1100,  8, 4'b1000, 16'd0);  // 8-cycle B pulse
    tbl[5]  = mk(4'b1000,  1, 4'b1000, 16'd0);
    tbl[6]  = mk(4'b1000,  1, 4'b1100, 16'd0);  // B rises 10 after pulse start
    tbl[7]  = mk(4'b1000, 12, 4'b1000, 16'd0);
    tbl[8]  = mk(4'b0100, 10, 4'b0101, 16'd1);  // illegal A/B swap
    tbl[9]  = mk(4'b0101,  1, 4'b0100, 16'd0);  // clear
    tbl[10] = mk(4'b1000, 10, 4'b1001, 16'd1);
    tbl[11] = mk(4'b0100,  9, 4'b1001, 16'd1);
    tbl[12] = mk(4'b0101,  1, 4'b0100, 16'd0);  // clear wins over illegal

    reset = 1'b1; A_raw = 1'b0; B_raw = 1'b0; I_raw = 1'b0; error_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_12MHz);
    chk("rst_A", {31'b0, A}, 32'd0);
    chk("rst_B", {31'b0, B}, 32'd0);
    chk("rst_I", {31'b0, I}, 32'd0);
    chk("rst_idx", {31'b0, index_pulse}, 32'd0);
    chk("rst_cnt", {16'b0, error_count}, 32'd0);
    chk("rst_flag", {31'b0, error_flag}, 32'd0);
    reset = 1'b0;
    repeat (20) tick();

    for (int r = 0; r < 13; r++) begin
      {A_raw, B_raw, I_raw, error_clear} = tbl[r].in;
      repeat (tbl[r].n) tick();
      chk($sformatf("row%0d_A", r), {31'b0, A}, {31'b0, tbl[r].exp[3]});
      chk($sformatf("row%0d_B", r), {31'b0, B}, {31'b0, tbl[r].exp[2]});
      chk($sformatf("row%0d_I", r), {31'b0, I}, {31'b0, tbl[r].exp[1]});
      chk($sformatf("row%0d_flag", r), {31'b0, error_flag}, {31'b0, tbl[r].exp[0]});
      chk($sformatf("row%0d_cnt", r), {16'b0, error_count}, {16'b0, tbl[r].cnt});
    end
    error_clear = 1'b0;

    // Saturation on the 2-bit instance, then clear coincident with an illegal edge.
    for (int t = 0; t < 4; t++) begin
      A_raw = ~A_raw; B_raw = ~B_raw;
      repeat (10) tick();
      chk($sformatf("sat%0d_cnt_s", t), {30'b0, error_count_s}, (t < 3) ? 32'(t + 1) : 32'd3);
    end
    chk("sat_cnt", {16'b0, error_count}, 32'd4);
    chk("sat_flag", {31'b0, error_flag}, 32'd1);
    A_raw = ~A_raw; B_raw = ~B_raw;
    repeat (9) tick();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("satclr_cnt_s", {30'b0, error_count_s}, 32'd0);
    chk("satclr_cnt", {16'b0, error_count}, 32'd0);
    chk("satclr_flag", {31'b0, error_flag}, 32'd0);
    chk("satclr_A", {31'b0, A}, 32'd1);
    chk("satclr_B", {31'b0, B}, 32'd0);

    // Index: 20-cycle high, pulse only on the 11th edge, nothing on the fall.
    I_raw = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk($sformatf("idx_t%0d", t), {31'b0, index_pulse}, (t == 11) ? 32'd1 : 32'd0);
      if (t == 20) I_raw = 1'b0;
    end
    chk("idx_I_low", {31'b0, I}, 32'd0);
    chk("idx_flag", {31'b0, error_flag}, 32'd0);

    // Reset in the middle of filtering A's fall.
    A_raw = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_A", {31'b0, A}, 32'd0);
    chk("async_B", {31'b0, B}, 32'd0);
    A_raw = 1'b1; B_raw = 1'b1;
    @(negedge clk_12MHz);
    @(negedge clk_12MHz);
    reset = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk($sformatf("rel_t%0d_A", t), {31'b0, A}, (t >= 10) ? 32'd1 : 32'd0);
      chk($sformatf("rel_t%0d_B", t), {31'b0, B}, (t >= 10) ? 32'd1 : 32'd0);
      chk($sformatf("rel_t%0d_cnt", t), {16'b0, error_count}, 32'd0);
    end
    chk("rel_flag", {31'b0, error_flag}, 32'd0);

    // Randomized raw activity with occasional simultaneous A/B flips and clears.
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 19) == 0) begin
        A_raw = ~A_raw; B_raw = ~B_raw;
      end else begin
        if ($urandom_range(0, 5) == 0) A_raw = ~A_raw;
        if ($urandom_range(0, 5) == 0) B_raw = ~B_raw;
      end
      if ($urandom_range(0, 7) == 0) I_raw = ~I_raw;
      error_clear = ($urandom_range(0, 60) == 0);
      if (cyc == 1500) begin
        reset = 1'b1;
        model_reset();
        @(negedge clk_12MHz);
        @(negedge clk_12MHz);
        reset = 1'b0;
      end
      tick();
      cmp_model(cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
